spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_if.sv | 33 +++
 rtl/spi_shift_reg.sv | 42 ++++
 rtl/spi_master.sv | 142 ++++++++++++++
 tb/tb_spi_master.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI master slice: FSM state enum, frame
// command encodings, frame/receive widths and bit-counter terminal values.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int FRAME_BITS = 10;  // 2-bit command + 8-bit payload
  localparam int RX_BITS    = 8;   // byte returned on MISO by RD_DATA
  localparam int CNT_W      = 4;   // bit counter width

  // Last counter value of each shifting phase.
  localparam logic [CNT_W-1:0] TX_END = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] RX_END = CNT_W'(RX_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_OUT,
    SHIFT_IN,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_if.sv
// -----------------------------------------------------------------------------
// spi_if
// Bundles the SPI master's user handshake and serial pins.
//   start/din            : frame request and frame word (user -> master)
//   busy/done            : frame/gap in progress, end-of-frame pulse
//   rx_data/rx_valid     : byte read by an RD_DATA frame and its strobe
//   SS_n/MOSI/MISO       : serial bus to the slave
// Modport master is the spi_master view; modport slave is the environment view.
// -----------------------------------------------------------------------------
interface spi_if;
  import spi_pkg::*;

  logic                  start;
  logic [FRAME_BITS-1:0] din;
  logic                  busy;
  logic                  done;
  logic [RX_BITS-1:0]    rx_data;
  logic                  rx_valid;
  logic                  SS_n;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  start, din, MISO,
    output busy, done, rx_data, rx_valid, SS_n, MOSI
  );

  modport slave (
    output start, din, MISO,
    input  busy, done, rx_data, rx_valid, SS_n, MOSI
  );

endinterface

// File: rtl/spi_shift_reg.sv
// -----------------------------------------------------------------------------
// spi_shift_reg
// 10-bit load / shift-left register shared by transmit and receive.
//   clk, rst : clock, synchronous active-high reset
//   load, d  : parallel load of the frame word (has priority over shift)
//   shift    : shift left one place, sin enters at the LSB
//   sout     : current MSB (next bit to transmit)
//   rx_next  : low byte as it will be after a shift with sin; lets the caller
//              capture the final received byte on the same edge as the last
//              MISO sample
// -----------------------------------------------------------------------------
module spi_shift_reg
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] d,
  input  logic                  sin,
  output logic                  sout,
  output logic [RX_BITS-1:0]    rx_next
);

  logic [FRAME_BITS-1:0] q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[FRAME_BITS-2:0], sin};
    end
  end

  assign sout    = q[FRAME_BITS-1];
  assign rx_next = {q[RX_BITS-2:0], sin};

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Frame-based SPI master. A frame is SS_n low, one idle bit (T0), ten command/
// payload bits MSB first (T1..T10) and, for RD_DATA, eight MISO bits sampled
// on the edges ending T11..T18. SS_n then stays high for GAP_CYCLES cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : spi_if.master (start/din in, busy/done/rx_data/rx_valid out,
//          SS_n/MOSI out, MISO in)
// Parameter GAP_CYCLES (1..15): SS_n-high cycles between frames.
// Every output is a flop; inputs only reach outputs through registers.
// -----------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic  clk,
  input  logic  rst,
  spi_if.master bus
);

  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_CYCLES - 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               rd_frame;

  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rx_valid_q, rx_valid_d;
  logic [RX_BITS-1:0] rx_data_q, rx_data_d;

  logic               sh_load, sh_shift, sh_sin, sh_msb;
  logic [RX_BITS-1:0] sh_rx_next;

  spi_shift_reg u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .shift   (sh_shift),
    .d       (bus.din),
    .sin     (sh_sin),
    .sout    (sh_msb),
    .rx_next (sh_rx_next)
  );

  // State register plus the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_frame   <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      // The command is latched with the word; din may change mid-frame.
      if (sh_load) rd_frame <= (cmd_t'(bus.din[9:8]) == RD_DATA);
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT_OUT;
          cnt_d   = '0;
        end
      end
      SHIFT_OUT: begin
        if (cnt == TX_END) begin
          state_d = rd_frame ? SHIFT_IN : GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT_IN: begin
        if (cnt == RX_END) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      GAP: begin
        // The edge closing the gap also serves as the start sampling point,
        // so a held start gives exactly GAP_CYCLES SS_n-high cycles.
        if (cnt == GAP_END) begin
          state_d = bus.start ? SHIFT_OUT : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
    endcase
  end

  // Output logic: next values of the output flops and shifter controls.
  always_comb begin
    sh_load    = (state_d == SHIFT_OUT) && (state != SHIFT_OUT);
    sh_shift   = ((state == SHIFT_OUT) && (cnt != TX_END)) || (state == SHIFT_IN);
    sh_sin     = (state == SHIFT_IN) ? bus.MISO : 1'b0;

    ss_n_d     = !((state_d == SHIFT_OUT) || (state_d == SHIFT_IN));
    busy_d     = (state_d != IDLE);
    // T0 follows an IDLE/GAP state, so the leading bit is always 0.
    mosi_d     = ((state == SHIFT_OUT) && (cnt != TX_END)) ? sh_msb : 1'b0;

    rx_valid_d = (state == SHIFT_IN) && (cnt == RX_END);
    done_d     = rx_valid_d ||
                 ((state == SHIFT_OUT) && (cnt == TX_END) && !rd_frame);
    rx_data_d  = rx_valid_d ? sh_rx_next : rx_data_q;
  end

  assign bus.SS_n     = ss_n_q;
  assign bus.MOSI     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master with GAP_CYCLES=3, a behavioural SPI slave
// with a 256-byte RAM, and a scoreboard of expected rx_data bytes.
// -----------------------------------------------------------------------------
module tb_spi_master;
  import spi_pkg::*;

  localparam int unsigned GAP = 3;

  logic clk = 1'b0;
  logic rst;

  spi_if bus ();

  spi_master #(.GAP_CYCLES(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         total    = 0;
  int         passed   = 0;
  int         done_cnt = 0;
  logic [7:0] exp_rx_q [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watches every cycle: MOSI idle when deselected, single-cycle pulses,
  // rx_valid coincident with done, rx_data against the scoreboard.
  task automatic monitor();
    logic done_prev;
    logic rxv_prev;
    done_prev = 1'b0;
    rxv_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.SS_n === 1'b1) check("mosi_idle", bus.MOSI, 0);
      if (bus.done === 1'b1) begin
        check("done_pulse", done_prev, 0);
        done_cnt++;
      end
      if (bus.rx_valid === 1'b1) begin
        check("rx_valid_pulse", rxv_prev, 0);
        check("rx_with_done", bus.done, 1);
        if (exp_rx_q.size() == 0) check("rx_unexpected", bus.rx_valid, 0);
        else check("rx_data", bus.rx_data, exp_rx_q.pop_front());
      end
      done_prev = bus.done;
      rxv_prev  = bus.rx_valid;
    end
  endtask

  // Slave / RAM model: collects 10 MOSI bits, executes the command, and for
  // RD_DATA presents mem[addr] MSB first during T11..T18.
  initial begin : slave_model
    logic [7:0] mem [256];
    logic [7:0] addr;
    logic [7:0] out;
    logic [9:0] sh;
    int         cyc;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'hA5] = 8'hC3;
    addr     = 8'h00;
    out      = 8'h00;
    sh       = '0;
    cyc      = 0;
    bus.MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.SS_n !== 1'b0) begin
        cyc      = 0;
        bus.MISO = 1'b0;
      end else begin
        if (cyc >= 1 && cyc <= 10) sh = {sh[8:0], bus.MOSI};
        if (cyc == 10) begin
          case (cmd_t'(sh[9:8]))
            WR_ADDR: addr      = sh[7:0];
            WR_DATA: mem[addr] = sh[7:0];
            RD_ADDR: addr      = sh[7:0];
            RD_DATA: out       = mem[addr];
          endcase
        end
        if (cyc >= 11 && cyc <= 18) bus.MISO = out[18-cyc];
        else bus.MISO = 1'b0;
        cyc++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Request a frame; returns in T0.
  task automatic launch(input logic [9:0] d);
    bus.din   = d;
    bus.start = 1'b1;
    tick();
  endtask

  // Runs from T0 until SS_n rises; changes din (and optionally pulses start)
  // at T3 to show the frame in flight is unaffected.
  task automatic capture(input logic [9:0] din_mid, input logic start_hold,
                         input logic start_t3, output logic [9:0] bits,
                         output int low);
    bits = '0;
    low  = 0;
    while (bus.SS_n === 1'b0 && low < 40) begin
      if (low == 0) begin
        bus.start = start_hold;
        check("t0_mosi", bus.MOSI, 0);
        check("t0_busy", bus.busy, 1);
      end
      if (low == 3) begin
        bus.start = start_t3;
        bus.din   = din_mid;
      end
      if (low == 4) bus.start = start_hold;
      if (low >= 1 && low <= 10) bits = {bits[8:0], bus.MOSI};
      low++;
      tick();
    end
  endtask

  task automatic wait_gap(input string tag);
    int g;
    g = 0;
    while (bus.busy === 1'b1 && g < 20) begin
      g++;
      tick();
    end
    check({tag, "_gap_len"}, g, GAP);
    check({tag, "_idle_ss"}, bus.SS_n, 1);
  endtask

  task automatic run_frame(input logic [9:0] d, input logic [7:0] rx_exp,
                           input logic start_t3, input string tag);
    logic [9:0] bits;
    int         low;
    logic       rd;
    rd = (d[9:8] == RD_DATA);
    if (rd) exp_rx_q.push_back(rx_exp);
    launch(d);
    capture(~d, 1'b0, start_t3, bits, low);
    check({tag, "_mosi"}, bits, d);
    check({tag, "_ss_low"}, low, rd ? 19 : 11);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_rx_valid"}, bus.rx_valid, rd);
    wait_gap(tag);
  endtask

  initial begin : stimulus
    logic [9:0] bits;
    int         low;
    int         cnt;

    fork
      monitor();
    join_none

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.din   = '0;
    repeat (3) tick();
    check("rst_ss_n", bus.SS_n, 1);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    rst = 1'b0;
    tick();

    // Write frame: 00_1010_0101 (also sets the slave address to A5).
    run_frame(10'b00_1010_0101, 8'h00, 1'b0, "wr_addr");
    check("rx_data_untouched", bus.rx_data, 8'h00);

    // Read frame: slave returns C3 from address A5.
    run_frame(10'b11_0000_0000, 8'hC3, 1'b0, "rd_c3");
    check("rx_data_c3", bus.rx_data, 8'hC3);

    // Start pulse during SHIFT_OUT must be ignored: exactly one frame.
    run_frame(10'b01_0011_1100, 8'h00, 1'b1, "ign_start");
    cnt = 0;
    repeat (20) begin
      if (bus.SS_n !== 1'b1) cnt++;
      tick();
    end
    check("ign_start_no_frame", cnt, 0);
    check("rx_data_hold", bus.rx_data, 8'hC3);

    // Reset at T5 of a read frame aborts it; start during reset is ignored.
    launch(10'b11_0000_0000);
    bus.start = 1'b0;
    repeat (5) tick();
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    check("abort_ss_n", bus.SS_n, 1);
    check("abort_mosi", bus.MOSI, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_rx_valid", bus.rx_valid, 0);
    check("abort_rx_data", bus.rx_data, 8'h00);
    rst       = 1'b0;
    bus.start = 1'b0;
    cnt = 0;
    repeat (25) begin
      if (bus.SS_n !== 1'b1) cnt++;
      tick();
    end
    check("abort_no_frame", cnt, 0);

    // Back-to-back frames with start held: gap is exactly GAP cycles and a
    // mid-frame din change is only picked up by the next frame.
    launch(10'b01_0110_1001);
    capture(10'b01_1001_0110, 1'b1, 1'b1, bits, low);
    check("b2b1_mosi", bits, 10'b01_0110_1001);
    check("b2b1_ss_low", low, 11);
    check("b2b1_done", bus.done, 1);
    cnt = 0;
    while (bus.SS_n === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    check("b2b_gap_high", cnt, GAP);
    capture(10'b01_1111_0000, 1'b0, 1'b0, bits, low);
    check("b2b2_mosi", bits, 10'b01_1001_0110);
    check("b2b2_ss_low", low, 11);
    check("b2b2_done", bus.done, 1);
    wait_gap("b2b2");

    // Full slave RAM round trip.
    run_frame({WR_ADDR, 8'h10}, 8'h00, 1'b0, "ram_wa");
    run_frame({WR_DATA, 8'h5A}, 8'h00, 1'b0, "ram_wd");
    run_frame({RD_ADDR, 8'h10}, 8'h00, 1'b0, "ram_ra");
    run_frame({RD_DATA, 8'h00}, 8'h5A, 1'b0, "ram_rd");
    check("ram_rx_data", bus.rx_data, 8'h5A);

    repeat (3) tick();
    check("done_count", done_cnt, 9);
    check("scoreboard_empty", exp_rx_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
